gcm_aes_job_sched: RTL and testbench
====================================

Name: gcm_aes_job_sched

Overview:
Round-robin scheduler that shares one GCM-AES core among NUM_REQ requesters. It arbitrates job requests and latches the winner's descriptor. It then sequences the winner's 128-bit input stream through the core's phases: key, IV, AAD, payload, and tag collection. It returns the tag, or a timeout error, tagged with the requester index. It sits between requester DMA/stream ports and the gcm_aes datapath, inside the AXI-attached IP.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LEN_W, 16, width of AAD/payload block-count fields (128-bit blocks)
KEY_BEATS, 1, key beats per job (1 = AES-128, 2 = AES-256)
TAG_TIMEOUT, 1024, max cycles waiting in TAG before error
ID_W (localparam), clog2(NUM_REQ), requester index width

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  job request per requester
req_ready  out  NUM_REQ  one-cycle acceptance pulse to winner
req_decrypt  in  NUM_REQ  1 = decrypt job
req_aad_blocks  in  NUM_REQ*LEN_W  AAD length in blocks, slice i for requester i
req_pt_blocks  in  NUM_REQ*LEN_W  payload length in blocks
gnt  out  NUM_REQ  one-hot, held for the whole job
s_tvalid  in  NUM_REQ  requester input stream valid
s_tdata  in  NUM_REQ*128  requester input stream data
s_tready  out  NUM_REQ  requester input stream ready
core_in_valid  out  1  beat to core
core_in_data  out  128  muxed beat
core_in_phase  out  2  0 key, 1 IV, 2 AAD, 3 payload
core_in_last  out  1  final beat of current phase
core_in_ready  in  1  core accepts beat
core_decrypt  out  1  latched mode
core_tag_valid  in  1  core tag available (single-cycle)
core_tag  in  128  core tag
tag_valid  out  1  one-cycle result pulse
tag_data  out  128  tag (0 on error)
tag_id  out  ID_W  requester index of finished job
tag_err  out  1  1 = timeout

Behaviour:
- FSM states: IDLE, KEY, IV, AAD, PT, TAG.
- Reset: state IDLE; rr pointer 0; beat/timeout counters 0.
- Reset values: all outputs 0 (gnt, req_ready, s_tready, core_in_*, core_decrypt, tag_*).
- Reset applies mid-job: the job is abandoned and no tag is emitted.
- IDLE arbitration: if any req_valid, pick the first set bit scanning from the rr pointer upward (wrapping).
- IDLE acceptance: in the same cycle, pulse req_ready[w], latch decrypt/aad/pt fields and index w, set gnt one-hot, go to KEY.
- rr pointer becomes w+1 mod NUM_REQ.
- Latency: req_valid sampled in IDLE at edge t gives gnt high after edge t, so the first beat is possible in cycle t+1.
- Streaming phases (KEY/IV/AAD/PT):
  - core_in_valid = s_tvalid[w] and core_in_data = s_tdata[w].
  - s_tready[w] = core_in_ready; s_tready of all other requesters = 0.
  - A beat transfers when valid && ready; the beat counter increments per transfer.
- Beats per phase: KEY = KEY_BEATS, IV = 1 (IV in bits [95:0], upper bits ignored), AAD = aad_blocks, PT = pt_blocks.
- core_in_last is high on the final beat of each phase.
- Phase advance: after the last beat, the counter clears and the next non-empty phase is entered. AAD is skipped if aad_blocks = 0; PT is skipped if pt_blocks = 0.
- With both lengths 0, IV goes directly to TAG.
- Lengths are latched at grant. req_valid/length changes after grant are ignored.
- TAG:
  - Streams are idle.
  - The timeout counter increments each cycle.
  - On core_tag_valid: tag_valid = 1, tag_data = core_tag, tag_id = w, tag_err = 0, then IDLE.
  - If the count reaches TAG_TIMEOUT-1 without a tag: tag_valid = 1, tag_err = 1, tag_data = 0, then IDLE.
  - A tag arriving in the same cycle as expiry wins (err = 0).
- On the return to IDLE, gnt clears. A new grant may happen the cycle after tag_valid, never the same cycle.
- core_tag_valid outside TAG is ignored.
- core_decrypt holds the latched mode from grant until return to IDLE.
- Counters are LEN_W wide. Max length 2^LEN_W-1 blocks with no wrap.

Test Plan:
- Single job: req 0, aad = 2, pt = 3, KEY_BEATS = 1, core_in_ready = 1 → phases 0,1,2,2,3,3,3 on consecutive cycles; last on beats 1,2,4,7; core_tag = 0xA5…A5 → tag_valid with id 0, err 0.
- Round robin: all 4 requesters asserting continuously with aad = pt = 0 → grant order 0,1,2,3,0; each gnt held until its tag_valid.
- Backpressure: core_in_ready toggling 1/0 and s_tvalid gaps during PT of 4 blocks → exactly 4 transfers, data order preserved, s_tready of the other requesters stays 0.
- Empty lengths and AES-256: aad = pt = 0, KEY_BEATS = 2 → beats K,K,IV, then TAG directly.
- Timeout: TAG_TIMEOUT = 16, no core_tag_valid → tag_valid with err = 1, tag_data = 0, 16 cycles after TAG entry. Tag on the exact expiry cycle → err = 0.
- Reset mid-PT: ARESET pulsed on beat 2 of 5 → next cycle all outputs 0, state IDLE, no tag_valid, rr restarts at requester 0.

Source files
------------

// File: rtl/gcm_aes_job_sched.sv
// Round-robin job scheduler in front of a single GCM-AES core.
// Grants one requester at a time, latches its job descriptor and walks its
// input stream through the key / IV / AAD / payload phases, then waits for
// the core's tag (or a timeout) and reports it with the requester index.
module gcm_aes_job_sched #(
    parameter  int NUM_REQ     = 4,
    parameter  int LEN_W       = 16,
    parameter  int KEY_BEATS   = 1,
    parameter  int TAG_TIMEOUT = 1024,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       req_decrypt,
    input  logic [NUM_REQ*LEN_W-1:0] req_aad_blocks,
    input  logic [NUM_REQ*LEN_W-1:0] req_pt_blocks,
    output logic [NUM_REQ-1:0]       gnt,
    input  logic [NUM_REQ-1:0]       s_tvalid,
    input  logic [NUM_REQ*128-1:0]   s_tdata,
    output logic [NUM_REQ-1:0]       s_tready,
    output logic                     core_in_valid,
    output logic [127:0]             core_in_data,
    output logic [1:0]               core_in_phase,
    output logic                     core_in_last,
    input  logic                     core_in_ready,
    output logic                     core_decrypt,
    input  logic                     core_tag_valid,
    input  logic [127:0]             core_tag,
    output logic                     tag_valid,
    output logic [127:0]             tag_data,
    output logic [ID_W-1:0]          tag_id,
    output logic                     tag_err
);

    localparam int TO_W = $clog2(TAG_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_KEY, S_IV, S_AAD, S_PT, S_TAG} state_t;

    state_t             state_q;
    logic [ID_W-1:0]    rr_q;
    logic [ID_W-1:0]    win_q;
    logic               dec_q;
    logic [LEN_W-1:0]   aad_q;
    logic [LEN_W-1:0]   pt_q;
    logic [LEN_W-1:0]   beat_q;
    logic [TO_W-1:0]    to_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] req_ready_q;
    logic               tag_valid_q;
    logic [127:0]       tag_data_q;
    logic [ID_W-1:0]    tag_id_q;
    logic               tag_err_q;

    logic               pick_vld;
    logic [ID_W-1:0]    pick_idx;
    logic               streaming;
    logic [LEN_W-1:0]   phase_beats;
    logic [1:0]         phase_code;
    state_t             adv_state_d;
    logic               beat_last;
    logic               xfer;

    // Round-robin pick: first requesting index at or above the rr pointer, wrapping.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pick_vld = 1'b0;
        pick_idx = '0;
        // Scan from the farthest offset down so the nearest requester is the last (winning) assignment.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[(int'(rr_q) + i) % NUM_REQ]) begin
                pick_vld = 1'b1;
                pick_idx = ID_W'((int'(rr_q) + i) % NUM_REQ);
            end
        end
    end

    // Per-phase beat count, phase code and the phase that follows (skipping empty AAD/payload).
    always_comb begin
        streaming   = 1'b0;
        phase_beats = '0;
        phase_code  = 2'd0;
        adv_state_d = S_TAG;
        case (state_q)
            S_KEY: begin
                streaming   = 1'b1;
                phase_beats = LEN_W'(KEY_BEATS);
                phase_code  = 2'd0;
                adv_state_d = S_IV;
            end
            S_IV: begin
                streaming   = 1'b1;
                phase_beats = LEN_W'(1);
                phase_code  = 2'd1;
                adv_state_d = (aad_q != '0) ? S_AAD : ((pt_q != '0) ? S_PT : S_TAG);
            end
            S_AAD: begin
                streaming   = 1'b1;
                phase_beats = aad_q;
                phase_code  = 2'd2;
                adv_state_d = (pt_q != '0) ? S_PT : S_TAG;
            end
            S_PT: begin
                streaming   = 1'b1;
                phase_beats = pt_q;
                phase_code  = 2'd3;
                adv_state_d = S_TAG;
            end
            default: ;
        endcase
    end

    assign beat_last = streaming && (beat_q == phase_beats - 1'b1);
    assign xfer      = streaming && s_tvalid[win_q] && core_in_ready;

    // Stream mux: only the granted requester sees core_in_ready; everything is quiet outside streaming phases.
    always_comb begin
        core_in_valid = streaming && s_tvalid[win_q];
        core_in_data  = streaming ? s_tdata[win_q*128 +: 128] : '0;
        core_in_phase = streaming ? phase_code : 2'd0;
        core_in_last  = beat_last;
        s_tready      = '0;
        if (streaming) s_tready[win_q] = core_in_ready;
    end

    // Job FSM: arbitration, phase sequencing, tag wait / timeout and the registered outputs.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
            state_q     <= S_IDLE;
            rr_q        <= '0;
            win_q       <= '0;
            dec_q       <= 1'b0;
            aad_q       <= '0;
            pt_q        <= '0;
            beat_q      <= '0;
            to_q        <= '0;
            gnt_q       <= '0;
            req_ready_q <= '0;
            tag_valid_q <= 1'b0;
            tag_data_q  <= '0;
            tag_id_q    <= '0;
            tag_err_q   <= 1'b0;
        end else begin
            req_ready_q <= '0;
            tag_valid_q <= 1'b0;
            tag_data_q  <= '0;
            tag_id_q    <= '0;
            tag_err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        state_q     <= S_KEY;
                        win_q       <= pick_idx;
                        rr_q        <= (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                        dec_q       <= req_decrypt[pick_idx];
                        aad_q       <= req_aad_blocks[pick_idx*LEN_W +: LEN_W];
                        pt_q        <= req_pt_blocks[pick_idx*LEN_W +: LEN_W];
                        gnt_q       <= NUM_REQ'(1) << pick_idx;
                        req_ready_q <= NUM_REQ'(1) << pick_idx;
                        beat_q      <= '0;
                        to_q        <= '0;
                    end
                end
                S_KEY, S_IV, S_AAD, S_PT: begin
                    if (xfer) begin
                        if (beat_last) begin
                            beat_q  <= '0;
                            to_q    <= '0;
                            state_q <= adv_state_d;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                S_TAG: begin
                    // A tag that arrives on the expiry cycle takes priority over the timeout.
                    if (core_tag_valid || (to_q == TO_W'(TAG_TIMEOUT - 1))) begin
                        tag_valid_q <= 1'b1;
                        tag_data_q  <= core_tag_valid ? core_tag : '0;
                        tag_err_q   <= !core_tag_valid;
                        tag_id_q    <= win_q;
                        state_q     <= S_IDLE;
                        gnt_q       <= '0;
                        dec_q       <= 1'b0;
                        to_q        <= '0;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign gnt          = gnt_q;
    assign core_decrypt = dec_q;
    assign tag_valid    = tag_valid_q;
    assign tag_data     = tag_data_q;
    assign tag_id       = tag_id_q;
    assign tag_err      = tag_err_q;

endmodule

// File: tb/tb_gcm_aes_job_sched.sv
// Self-checking bench for gcm_aes_job_sched: directed scenarios plus random
// traffic, all compared every cycle against a queue-based job model.
module tb_gcm_aes_job_sched;

    localparam int NUM_REQ     = 4;
    localparam int LEN_W       = 16;
    localparam int KEY_BEATS   = 1;
    localparam int TAG_TIMEOUT = 16;
    localparam int ID_W        = 2;

    logic                     ACLK;
    logic                     ARESET;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       req_decrypt;
    logic [NUM_REQ*LEN_W-1:0] req_aad_blocks;
    logic [NUM_REQ*LEN_W-1:0] req_pt_blocks;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       s_tvalid;
    logic [NUM_REQ*128-1:0]   s_tdata;
    logic [NUM_REQ-1:0]       s_tready;
    logic                     core_in_valid;
    logic [127:0]             core_in_data;
    logic [1:0]               core_in_phase;
    logic                     core_in_last;
    logic                     core_in_ready;
    logic                     core_decrypt;
    logic                     core_tag_valid;
    logic [127:0]             core_tag;
    logic                     tag_valid;
    logic [127:0]             tag_data;
    logic [ID_W-1:0]          tag_id;
    logic                     tag_err;

    gcm_aes_job_sched #(
        .NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .KEY_BEATS(KEY_BEATS), .TAG_TIMEOUT(TAG_TIMEOUT)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_decrypt(req_decrypt),
        .req_aad_blocks(req_aad_blocks), .req_pt_blocks(req_pt_blocks), .gnt(gnt),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tready(s_tready),
        .core_in_valid(core_in_valid), .core_in_data(core_in_data),
        .core_in_phase(core_in_phase), .core_in_last(core_in_last),
        .core_in_ready(core_in_ready), .core_decrypt(core_decrypt),
        .core_tag_valid(core_tag_valid), .core_tag(core_tag),
        .tag_valid(tag_valid), .tag_data(tag_data), .tag_id(tag_id), .tag_err(tag_err)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural job model ----------------
    // A job is a queue of remaining beat phases; an empty queue while busy means waiting for the tag.
    bit                 m_busy;
    int                 m_w;
    bit                 m_dec;
    int                 m_seq[$];
    int                 m_tcnt;
    int                 m_rr;
    logic [NUM_REQ-1:0] m_rrdy;
    bit                 m_tv;
    logic [127:0]       m_td;
    int                 m_tid;
    bit                 m_terr;

    // Observation logs used by the directed scenarios.
    int                 grant_log[$];
    int                 xfer_phase[$];
    bit                 xfer_last[$];
    logic [127:0]       xfer_data[$];
    int                 last_xfer_cyc;
    int                 tag_cyc;
    int                 n_tags;
    logic [127:0]       tag_d_log;
    bit                 tag_err_log;
    int                 tag_id_log;
    logic [NUM_REQ-1:0] prev_gnt;

    logic [NUM_REQ-1:0] e_gnt, e_str;
    bit                 strm, e_last;
    int                 e_phase, k, aadn, ptn;

    task automatic clear_logs();
        grant_log.delete();
        xfer_phase.delete();
        xfer_last.delete();
        xfer_data.delete();
        n_tags = 0;
        last_xfer_cyc = 0;
        tag_cyc = 0;
    endtask

    initial begin
        m_busy = 0; m_w = 0; m_dec = 0; m_tcnt = 0; m_rr = 0;
        m_rrdy = '0; m_tv = 0; m_td = '0; m_tid = 0; m_terr = 0;
        prev_gnt = '0;
        clear_logs();
    end

    // Compare process: check this cycle's outputs against the model, log events, then advance the model.
    always @(negedge ACLK) begin
        cyc++;
        strm    = m_busy && (m_seq.size() > 0);
        e_gnt   = m_busy ? (NUM_REQ'(1) << m_w) : '0;
        e_phase = strm ? m_seq[0] : 0;
        e_last  = strm && ((m_seq.size() == 1) || (m_seq[1] != m_seq[0]));
        e_str   = (strm && core_in_ready) ? (NUM_REQ'(1) << m_w) : '0;

        check("gnt", gnt, e_gnt);
        check("req_ready", req_ready, m_rrdy);
        check("core_decrypt", core_decrypt, m_busy ? m_dec : 1'b0);
        check("core_in_valid", core_in_valid, strm ? s_tvalid[m_w] : 1'b0);
        check("core_in_data", core_in_data, strm ? s_tdata[m_w*128 +: 128] : 128'h0);
        check("core_in_phase", core_in_phase, e_phase);
        check("core_in_last", core_in_last, e_last);
        check("s_tready", s_tready, e_str);
        check("tag_valid", tag_valid, m_tv);
        check("tag_data", tag_data, m_td);
        check("tag_id", tag_id, m_tid);
        check("tag_err", tag_err, m_terr);

        if (gnt != '0 && prev_gnt == '0)
            for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) grant_log.push_back(i);
        prev_gnt = gnt;
        if (core_in_valid && core_in_ready) begin
            xfer_phase.push_back(int'(core_in_phase));
            xfer_last.push_back(core_in_last);
            xfer_data.push_back(core_in_data);
            last_xfer_cyc = cyc;
        end
        if (tag_valid) begin
            n_tags++;
            tag_cyc     = cyc;
            tag_d_log   = tag_data;
            tag_err_log = tag_err;
            tag_id_log  = int'(tag_id);
        end

        m_rrdy = '0; m_tv = 0; m_td = '0; m_tid = 0; m_terr = 0;
        if (ARESET) begin
            m_busy = 0; m_rr = 0; m_tcnt = 0; m_dec = 0;
            m_seq.delete();
        end else if (!m_busy) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                k = (m_rr + i) % NUM_REQ;
                if (req_valid[k]) begin
                    m_busy = 1;
                    m_w    = k;
                    m_dec  = req_decrypt[k];
                    m_rr   = (k + 1) % NUM_REQ;
                    m_rrdy = NUM_REQ'(1) << k;
                    m_tcnt = 0;
                    aadn   = int'(req_aad_blocks[k*LEN_W +: LEN_W]);
                    ptn    = int'(req_pt_blocks[k*LEN_W +: LEN_W]);
                    m_seq.delete();
                    repeat (KEY_BEATS) m_seq.push_back(0);
                    m_seq.push_back(1);
                    repeat (aadn) m_seq.push_back(2);
                    repeat (ptn) m_seq.push_back(3);
                    break;
                end
            end
        end else if (strm) begin
            if (s_tvalid[m_w] && core_in_ready) begin
                void'(m_seq.pop_front());
                if (m_seq.size() == 0) m_tcnt = 0;
            end
        end else begin
            if (core_tag_valid) begin
                m_tv = 1; m_td = core_tag; m_tid = m_w; m_terr = 0;
                m_busy = 0; m_dec = 0;
            end else if (m_tcnt == TAG_TIMEOUT - 1) begin
                m_tv = 1; m_td = '0; m_tid = m_w; m_terr = 1;
                m_busy = 0; m_dec = 0;
            end else begin
                m_tcnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NUM_REQ; i++)
            s_tdata[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic set_job(input int r, input int aad, input int pt, input bit dec);
        req_aad_blocks[r*LEN_W +: LEN_W] = LEN_W'(aad);
        req_pt_blocks[r*LEN_W +: LEN_W]  = LEN_W'(pt);
        req_decrypt[r]                   = dec;
    endtask

    task automatic wait_gnt(input string name, input int budget);
        for (int i = 0; i < budget && gnt == '0; i++) step();
        check(name, gnt != '0, 1'b1);
    endtask

    task automatic wait_tags(input string name, input int n, input int budget);
        for (int i = 0; i < budget && n_tags < n; i++) begin
            rand_data();
            step();
        end
        check(name, n_tags >= n, 1'b1);
    endtask

    int           exp_ph[7]   = '{0, 1, 2, 2, 3, 3, 3};
    bit           exp_last[7] = '{1, 1, 0, 1, 0, 0, 1};
    int           exp_rr[5]   = '{0, 1, 2, 3, 0};
    logic [127:0] pt_vals[$];
    logic [127:0] next_val;
    bit           hs;

    initial begin
        ARESET = 1'b1;
        req_valid = '0; req_decrypt = '0; req_aad_blocks = '0; req_pt_blocks = '0;
        s_tvalid = '0; s_tdata = '0; core_in_ready = 1'b0;
        core_tag_valid = 1'b0; core_tag = '0;
        repeat (3) step();
        check("reset_gnt", gnt, '0);
        check("reset_tag_valid", tag_valid, 1'b0);
        ARESET = 1'b0;

        // Single job: req 0, aad 2, pt 3, full throughput, tag A5..A5.
        clear_logs();
        set_job(0, 2, 3, 1'b1);
        s_tvalid = '1; core_in_ready = 1'b1; rand_data();
        req_valid = 4'b0001;
        wait_gnt("t1_gnt_wait", 10);
        req_valid = '0;
        set_job(0, 9, 9, 1'b0);   // changes after grant must be ignored
        for (int i = 0; i < 20 && xfer_phase.size() < 7; i++) begin rand_data(); step(); end
        check("t1_nxfer", xfer_phase.size(), 7);
        for (int i = 0; i < 7 && i < xfer_phase.size(); i++) begin
            check("t1_phase", xfer_phase[i], exp_ph[i]);
            check("t1_last", xfer_last[i], exp_last[i]);
        end
        repeat (2) step();
        core_tag = {16{8'hA5}}; core_tag_valid = 1'b1;
        step();
        core_tag_valid = 1'b0;
        wait_tags("t1_tag_wait", 1, 10);
        check("t1_tag_id", tag_id_log, 0);
        check("t1_tag_err", tag_err_log, 1'b0);
        check("t1_tag_data", tag_d_log, {16{8'hA5}});
        repeat (3) step();

        // Round robin from reset with empty jobs; the tag input is left high throughout.
        ARESET = 1'b1; step(); ARESET = 1'b0;
        clear_logs();
        for (int r = 0; r < NUM_REQ; r++) set_job(r, 0, 0, r[0]);
        core_tag_valid = 1'b1; core_tag = {$urandom, $urandom, $urandom, $urandom};
        req_valid = '1;
        wait_tags("t2_tag_wait", 5, 100);
        req_valid = '0;
        core_tag_valid = 1'b0;
        check("t2_ngrants", grant_log.size() >= 5, 1'b1);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) check("t2_order", grant_log[i], exp_rr[i]);
        repeat (30) step();

        // Backpressure on req 2 with 4 payload blocks; data advances only on handshakes.
        clear_logs();
        set_job(2, 0, 4, 1'b0);
        req_valid = 4'b0100;
        next_val = 128'h100;
        s_tdata[2*128 +: 128] = next_val;
        for (int i = 0; i < 60; i++) begin
            if (gnt != '0) req_valid = '0;
            s_tvalid = 4'($urandom);
            core_in_ready = i[0];
            #1;
            hs = s_tvalid[2] && s_tready[2];
            step();
            if (hs) next_val = next_val + 1;
            s_tdata[2*128 +: 128] = next_val;
        end
        pt_vals.delete();
        for (int i = 0; i < xfer_phase.size(); i++) if (xfer_phase[i] == 3) pt_vals.push_back(xfer_data[i]);
        check("t3_pt_beats", pt_vals.size(), 4);
        for (int i = 1; i < pt_vals.size(); i++) check("t3_pt_order", pt_vals[i], pt_vals[0] + 128'(i));
        req_valid = '0; s_tvalid = '1; core_in_ready = 1'b1;
        repeat (30) step();

        // Timeout: req 1, aad 1, no tag ever.
        clear_logs();
        set_job(1, 1, 0, 1'b1);
        req_valid = 4'b0010;
        wait_gnt("t4_gnt_wait", 10);
        req_valid = '0;
        wait_tags("t4_tag_wait", 1, 60);
        check("t4_tag_err", tag_err_log, 1'b1);
        check("t4_tag_data", tag_d_log, 128'h0);
        check("t4_tag_id", tag_id_log, 1);
        check("t4_latency", tag_cyc - last_xfer_cyc, TAG_TIMEOUT + 1);
        repeat (2) step();

        // Tag on the exact expiry cycle wins: gnt cycle g = KEY, g+1 IV, g+2 TAG count 0, g+17 count 15.
        clear_logs();
        set_job(3, 0, 0, 1'b0);
        req_valid = 4'b1000;
        wait_gnt("t5_gnt_wait", 10);
        req_valid = '0;
        repeat (17) step();
        core_tag = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        core_tag_valid = 1'b1;
        step();
        core_tag_valid = 1'b0;
        wait_tags("t5_tag_wait", 1, 10);
        check("t5_tag_err", tag_err_log, 1'b0);
        check("t5_tag_data", tag_d_log, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        check("t5_tag_id", tag_id_log, 3);
        repeat (2) step();

        // Reset on payload beat 2 of 5, then rr must restart at requester 0.
        set_job(0, 0, 5, 1'b1);
        req_valid = 4'b0001;
        wait_gnt("t6_gnt_wait", 10);
        req_valid = '0;
        repeat (3) step();
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        clear_logs();
        check("t6_gnt", gnt, '0);
        check("t6_in_valid", core_in_valid, 1'b0);
        check("t6_s_tready", s_tready, '0);
        check("t6_decrypt", core_decrypt, 1'b0);
        req_valid = '1;
        repeat (8) step();
        check("t6_no_tag", n_tags, 0);
        check("t6_rr_restart", grant_log.size() > 0 ? grant_log[0] : -1, 0);
        req_valid = '0;
        repeat (30) step();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            req_valid = 4'($urandom);
            for (int r = 0; r < NUM_REQ; r++)
                set_job(r, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
            s_tvalid = 4'($urandom);
            core_in_ready = ($urandom_range(0, 3) != 0);
            core_tag_valid = ($urandom_range(0, 5) == 0);
            core_tag = {$urandom, $urandom, $urandom, $urandom};
            rand_data();
            step();
        end
        req_valid = '0; core_tag_valid = 1'b0;
        repeat (40) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_fail);
        $fatal(1);
    end

endmodule
